decoder_bin_hold: RTL and testbench
===================================

Name: decoder_bin_hold

Overview:
- Registered 3-to-8 binary-to-one-hot decoder: the receive-side counterpart of the team's 8-to-3 binary encoder.
- Accepts codes through a valid/ready handshake and drives one one-hot line per code for a fixed number of cycles (pulse hold).
- A one-entry buffer keeps the output continuously busy when codes arrive back to back.
- Sits between a code source (encoder output or a control FSM) and per-line strobes or enables.

Parameters:
- W, 3, code width; fixed at 3 for encoder compatibility.
- N, 2**W, number of one-hot outputs; derived, not overridden.
- HOLD, 4, cycles each decoded line stays asserted; legal range 1..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 freezes the block.
- in_valid  input  1  source has a code.
- in_ready  output  1  block accepts a code this cycle.
- in_code  input  W  code, using the encoder's bit-reversed mapping.
- out_onehot  output  N  registered one-hot line; all zero when idle.
- out_valid  output  1  a line is being held.
- done  output  1  one-cycle pulse on the last hold cycle of each code.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Mapping: line index k is bit-reversed from the code, so k[2]=in_code[0], k[1]=in_code[1], k[0]=in_code[2].
  - 3'b100 -> out_onehot 8'h02.
  - 3'b001 -> 8'h10.
  - 3'b110 -> 8'h08.
- Accept rule: a code is accepted when in_valid && in_ready. in_ready = en && !buf_full && !rst (combinational).
- Reset values, applied on the cycle after rst is sampled high:
  - state=IDLE, out_onehot=0, out_valid=0, done=0.
  - buf_full=0, hold counter=0.
  - A buffered or active code is discarded, including on reset mid-hold.
- IDLE state:
  - Accept: load the decoded line into out_onehot, set counter=0, go to ACTIVE.
  - Latency: the line appears the cycle after acceptance.
- ACTIVE state, en=1:
  - out_valid=1.
  - Counter increments each cycle.
  - An accept while the buffer is empty stores the code in the buffer.
- ACTIVE state, last cycle (counter==HOLD-1, en=1): done=1, then exactly one of:
  - Buffer full: load the buffered line into the output, clear the buffer, counter=0, stay ACTIVE, no gap cycle.
  - Buffer empty and an accept this same cycle: load the new line directly, counter=0, stay ACTIVE.
  - Otherwise: go to IDLE. out_onehot and out_valid are 0 on the next cycle.
- en=0 (any state):
  - Counter, output, buffer and state are all held.
  - in_ready=0 and done=0.
  - Resuming en=1 continues the count where it stopped.
- HOLD=1: every output cycle is also a last cycle. done stays high, and a continuous valid stream is accepted every cycle at full throughput.
- Buffer-full backpressure: in_ready stays 0 from the cycle after the buffer fills until the cycle after the swap.
- Width rule: counter width is $clog2(HOLD+1). Compare against HOLD-1 at counter width; no wrap past HOLD-1.
- Invariant: out_onehot is either zero or has exactly one bit set.

Decomposition:
- Shared package:
  - state enum {IDLE, ACTIVE}.
  - Constant for the code width (3).
  - Function bin2onehot(code) implementing the bit-reversed mapping. The encoder and its bench use the same function for cross-checks.
- One natural sub-module: onehot_buf1, a one-entry valid/ready holding register (data, full, load, drain).
- FSM, counter and output register live in the top.

Test Plan:
1. Reset, en=1, HOLD=4, single code 3'b100 accepted at cycle t -> out_onehot=8'h02 and out_valid=1 on t+1..t+4; done only at t+4; all zero at t+5.
2. Sweep all 8 codes, each separated by idle cycles -> 3'b000->8'h01, 3'b100->8'h02, 3'b010->8'h04, 3'b110->8'h08, 3'b001->8'h10, 3'b101->8'h20, 3'b011->8'h40, 3'b111->8'h80. Onehot-or-zero checked every cycle.
3. Back-to-back: 3'b100 at t, 3'b110 held valid from t+1 -> second code buffered at t+1; in_ready=0 t+2..t+4; 8'h02 on t+1..t+4, then 8'h08 on t+5..t+8 with no gap.
4. en low for 3 cycles during hold cycle 2 -> output held, counter frozen, in_ready=0, done=0; line de-asserts 3 cycles later than in scenario 1.
5. rst pulsed during ACTIVE with the buffer full -> next cycle out_onehot=0, out_valid=0, in_ready=1; the buffered code never appears.
6. HOLD=1 build, continuous valid stream of codes 0..7 (bit-reversed order) -> 8'h01, 8'h02, ..., 8'h80 on consecutive cycles; in_ready and done constantly 1.

Source files
------------

// File: rtl/decoder_bin_hold_pkg.sv
// decoder_bin_hold_pkg: shared constants, state type and code-to-line mapping
// for the bit-reversed 3-to-8 decoder. The encoder and its bench use the same
// function for cross-checks.
package decoder_bin_hold_pkg;
    localparam int CODE_W  = 3;
    localparam int LINES_N = 2 ** CODE_W;
    typedef enum logic {IDLE, ACTIVE} state_e;
    // Line index is the code read MSB-first from bit 0 (encoder's reversed order)
    function automatic logic [LINES_N-1:0] bin2onehot(input logic [CODE_W-1:0] code);
        return LINES_N'(1) << {code[0], code[1], code[2]};
    endfunction
endpackage

// File: rtl/decoder_bin_hold_onehot_buf1.sv
// onehot_buf1: one-entry holding register for a decoded line.
// Ports: clk, rst (sync, active-high); load_i stores data_i and sets full;
// drain_i clears full; data_o/full_o expose the held entry.
// load_i and drain_i are never asserted together by the parent.
module onehot_buf1
    import decoder_bin_hold_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic [LINES_N-1:0] data_i,
    output logic [LINES_N-1:0] data_o,
    output logic               full_o
);
    logic [LINES_N-1:0] data_q;
    logic               full_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end
    end
    assign data_o = data_q;
    assign full_o = full_q;
endmodule

// File: rtl/decoder_bin_hold.sv
// decoder_bin_hold: registered 3-to-8 bit-reversed decoder with pulse hold.
// Ports: clk, rst (sync, active-high), en (freeze when low);
// in_valid/in_ready/in_code accept a code; out_onehot holds the decoded line
// for HOLD enabled cycles, out_valid flags a held line, done pulses on the
// last hold cycle. A one-entry buffer lets back-to-back codes run gap-free.
module decoder_bin_hold
    import decoder_bin_hold_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  in_code,
    output logic [LINES_N-1:0] out_onehot,
    output logic               out_valid,
    output logic               done
);
    localparam int CW = $clog2(HOLD + 1);
    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [LINES_N-1:0] onehot_q;
    logic [LINES_N-1:0] buf_data;
    logic               buf_full;
    logic               accept;
    logic               last;
    assign in_ready = en && !buf_full && !rst;
    assign accept   = in_valid && in_ready;
    assign last     = (state_q == ACTIVE) && (cnt_q == CW'(HOLD - 1));
    assign done     = en && last;
    // Mid-hold arrivals park in the buffer; on the last cycle they go straight out
    onehot_buf1 u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept && (state_q == ACTIVE) && !last),
        .drain_i (done && buf_full),
        .data_i  (bin2onehot(in_code)),
        .data_o  (buf_data),
        .full_o  (buf_full)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
        end else if (en) begin
            if (state_q == IDLE) begin
                if (accept) begin
                    onehot_q <= bin2onehot(in_code);
                    cnt_q    <= '0;
                    state_q  <= ACTIVE;
                end
            end else if (last) begin
                cnt_q <= '0;
                if (buf_full) begin
                    onehot_q <= buf_data;
                end else if (accept) begin
                    onehot_q <= bin2onehot(in_code);
                end else begin
                    onehot_q <= '0;
                    state_q  <= IDLE;
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
    assign out_onehot = onehot_q;
    assign out_valid  = (state_q == ACTIVE);
endmodule

// File: tb/tb_decoder_bin_hold.sv
// tb_decoder_bin_hold: scoreboard bench for HOLD=4 and HOLD=1 decoders
module tb_decoder_bin_hold;
    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b1, in_valid = 1'b0, in_ready;
    logic [2:0] in_code = '0;
    logic [7:0] out_onehot;
    logic       out_valid, done;
    logic       rst1 = 1'b1, en1 = 1'b1, in_valid1 = 1'b0, in_ready1;
    logic [2:0] in_code1 = '0;
    logic [7:0] out_onehot1;
    logic       out_valid1, done1;
    int         checks = 0, errors = 0;
    logic       armed = 1'b0;
    logic [7:0] exp_q[2][$];
    int         held[2] = '{0, 0};

    always #5 clk = ~clk;

    decoder_bin_hold #(.HOLD(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_onehot(out_onehot), .out_valid(out_valid), .done(done)
    );
    decoder_bin_hold #(.HOLD(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_code(in_code1), .out_onehot(out_onehot1), .out_valid(out_valid1), .done(done1)
    );

    task automatic chk(input int i, input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %h expected %h at %0t", i, name, got, exp, $time);
        end
    endtask

    // Each accepted code is a job shown for HOLD enabled cycles; at most one waits behind the shown one
    task automatic sb(input int i, input int hold, input logic r, input logic e, input logic v,
                      input logic rdy, input logic [2:0] code, input logic [7:0] oh,
                      input logic ov, input logic d);
        logic       busy, exp_rdy;
        int         k;
        busy    = exp_q[i].size() != 0;
        exp_rdy = e && !r && exp_q[i].size() < 2;
        chk(i, "onehot", oh, busy ? exp_q[i][0] : 8'h00);
        chk(i, "valid", {7'd0, ov}, {7'd0, busy});
        chk(i, "ready", {7'd0, rdy}, {7'd0, exp_rdy});
        chk(i, "onehot0", {7'd0, $onehot0(oh)}, 8'd1);
        if (!r) chk(i, "done", {7'd0, d}, {7'd0, e && busy && held[i] == hold - 1});
        if (r) begin
            exp_q[i].delete();
            held[i] = 0;
        end else if (e) begin
            if (busy) begin
                held[i]++;
                if (held[i] == hold) begin
                    void'(exp_q[i].pop_front());
                    held[i] = 0;
                end
            end
            if (v && exp_rdy) begin
                k = 4 * code[0] + 2 * code[1] + code[2];
                exp_q[i].push_back(8'd1 << k);
            end
        end
    endtask

    always @(negedge clk) if (armed) begin
        sb(0, 4, rst, en, in_valid, in_ready, in_code, out_onehot, out_valid, done);
        sb(1, 1, rst1, en1, in_valid1, in_ready1, in_code1, out_onehot1, out_valid1, done1);
    end

    task automatic c0(input logic v, input logic [2:0] c, input logic e, input logic r);
        in_valid = v; in_code = c; en = e; rst = r;
        @(posedge clk); #1;
    endtask

    task automatic c1(input logic v, input logic [2:0] c, input logic e, input logic r);
        in_valid1 = v; in_code1 = c; en1 = e; rst1 = r;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] kk;
        @(posedge clk); #1;
        armed = 1'b1;
        c0(0, 0, 1, 1);
        repeat (2) c0(0, 0, 1, 0);
        c0(1, 3'b100, 1, 0);
        repeat (6) c0(0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            c0(1, 3'(k), 1, 0);
            repeat (6) c0(0, 0, 1, 0);
        end
        c0(1, 3'b100, 1, 0);
        c0(1, 3'b110, 1, 0);
        repeat (10) c0(0, 0, 1, 0);
        c0(1, 3'b100, 1, 0);
        c0(0, 0, 1, 0);
        repeat (3) c0(1, 3'b011, 0, 0);
        repeat (8) c0(0, 0, 1, 0);
        c0(1, 3'b100, 1, 0);
        c0(1, 3'b110, 1, 0);
        c0(0, 0, 1, 0);
        c0(1, 3'b111, 1, 1);
        repeat (8) c0(0, 0, 1, 0);
        repeat (400) c0(1'($urandom_range(1)), 3'($urandom), $urandom_range(5) != 0, $urandom_range(49) == 0);
        c0(0, 0, 1, 0);
        c1(0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            kk = 3'(k);
            c1(1, {kk[0], kk[1], kk[2]}, 1, 0);
        end
        repeat (3) c1(0, 0, 1, 0);
        repeat (200) c1($urandom_range(3) != 0, 3'($urandom), $urandom_range(7) != 0, $urandom_range(59) == 0);
        repeat (3) c1(0, 0, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
